// File: rtl/wb_host_pkg.sv
// rtl/wb_host_pkg.sv - shared opcodes, response codes and state encoding for the UART-to-Wishbone bridge
//
// Purpose: constants and types shared by wb_host_bridge and anything that
// needs to speak its byte protocol.
// Contents: command opcodes, response codes, bridge state encoding and an
// opcode classifier.

package wb_host_pkg;

    // Command opcodes (first byte of every command frame)
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    // Response codes (first byte returned for every command)
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_BUS   = 3'd3,
        ST_RESP  = 3'd4,
        ST_RDATA = 3'd5
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/wb_host_bridge.sv
// rtl/wb_host_bridge.sv - UART byte-stream to Wishbone classic master bridge
//
// Purpose: decodes read/write command frames arriving as bytes, runs one
// Wishbone classic cycle per command and returns a response code (plus four
// read-data bytes for a successful read) as a byte stream.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   tx_data, tx_valid,   byte to transmit; transfers when tx_valid && tx_ready
//   tx_ready
//   wb_adr_o, wb_dat_o,  Wishbone master address, write data, byte selects,
//   wb_sel_o, wb_we_o,   write enable, cycle and strobe
//   wb_cyc_o, wb_stb_o
//   wb_dat_i, wb_ack_i,  Wishbone read data and slave terminations
//   wb_err_i
//   busy                 high whenever the bridge is not idle

module wb_host_bridge
    import wb_host_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255,
    parameter int unsigned RX_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
    localparam int RT_W = $clog2(RX_TIMEOUT + 1);

    // Timers count from zero, so the last tolerated value is TIMEOUT-1.
    localparam logic [BT_W-1:0] BUS_LAST = BT_W'(BUS_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RX_LAST  = RT_W'(RX_TIMEOUT - 1);

    state_t            state;
    logic [1:0]        byte_cnt;
    logic              is_write;
    logic              rd_ok;      // response must be followed by read data
    logic [31:0]       rx_shift;   // incoming address/data bytes, MSB first
    logic [31:0]       tx_shift;   // captured read data awaiting transmission
    logic [BT_W-1:0]   bus_timer;
    logic [RT_W-1:0]   rx_timer;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_cnt  <= 2'd0;
            is_write  <= 1'b0;
            rd_ok     <= 1'b0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            bus_timer <= '0;
            rx_timer  <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= 4'h0;
            wb_we_o   <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (is_opcode(rx_data)) begin
                            is_write <= (rx_data == OP_WRITE);
                            byte_cnt <= 2'd0;
                            rx_timer <= '0;
                            state    <= ST_ADDR;
                        end else begin
                            rd_ok    <= 1'b0;
                            tx_data  <= RSP_NAK;
                            tx_valid <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end

                // Address and write-data collection share the shift register;
                // the counter wraps to zero after the 4th byte, ready for the
                // next field.
                ST_ADDR, ST_WDATA: begin
                    if (rx_valid) begin
                        rx_shift <= {rx_shift[23:0], rx_data};
                        rx_timer <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (state == ST_ADDR) begin
                                wb_adr_o <= {rx_shift[23:0], rx_data};
                                state    <= is_write ? ST_WDATA : ST_BUS;
                            end else begin
                                state    <= ST_BUS;
                            end
                        end
                    end else if (rx_timer == RX_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end

                // First BUS cycle launches the strobe; termination always
                // moves on to RESP, so a low strobe here means "not started".
                ST_BUS: begin
                    if (!wb_stb_o) begin
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_sel_o  <= 4'hF;
                        wb_we_o   <= is_write;
                        bus_timer <= '0;
                        if (is_write) begin
                            wb_dat_o <= rx_shift;
                        end
                    end else if (wb_ack_i || wb_err_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        wb_we_o  <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                        // Simultaneous ack and err is treated as an error.
                        if (wb_ack_i && !wb_err_i) begin
                            tx_data <= RSP_ACK;
                            rd_ok   <= !is_write;
                            if (!is_write) begin
                                tx_shift <= wb_dat_i;
                            end
                        end else begin
                            tx_data <= RSP_NAK;
                            rd_ok   <= 1'b0;
                        end
                    end else if (bus_timer == BUS_LAST) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        wb_we_o  <= 1'b0;
                        rd_ok    <= 1'b0;
                        tx_data  <= RSP_NAK;
                        tx_valid <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        bus_timer <= bus_timer + 1'b1;
                    end
                end

                // The response byte is held until accepted; a successful read
                // chains straight into the first data byte without a gap.
                ST_RESP: begin
                    if (tx_ready) begin
                        if (rd_ok) begin
                            tx_data  <= tx_shift[31:24];
                            tx_shift <= {tx_shift[23:0], 8'h00};
                            byte_cnt <= 2'd0;
                            state    <= ST_RDATA;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end

                ST_RDATA: begin
                    if (tx_ready) begin
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            rd_ok    <= 1'b0;
                            byte_cnt <= 2'd0;
                            state    <= ST_IDLE;
                        end else begin
                            tx_data  <= tx_shift[31:24];
                            tx_shift <= {tx_shift[23:0], 8'h00};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_bridge.sv
// tb/tb_wb_host_bridge.sv - directed table-driven bench for wb_host_bridge

module tb_wb_host_bridge;

    localparam int BT = 16;
    localparam int RT = 100;
    localparam int NV = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;

    always #5 clk = ~clk;

    wb_host_bridge #(.BUS_TIMEOUT(BT), .RX_TIMEOUT(RT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .busy     (busy)
    );

    // Slave modes: 0 ack, 1 err, 2 never respond, 3 ack and err together
    typedef struct {
        logic [71:0] cmd;       // command bytes, left-justified
        int          ncmd;
        int          mode;
        int          delay;     // slave terminates in this stb-high cycle
        logic [31:0] rdata;
        bit          rr;        // randomise tx_ready
        int          exp_cycles;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        bit          exp_we;
        int          exp_run;   // stb-high cycles expected
        logic [39:0] exp_tx;    // expected tx bytes, left-justified
        int          ntx;
    } vec_t;

    vec_t vecs[NV];

    int total = 0;
    int bad   = 0;

    int          slave_mode  = 2;
    int          slave_delay = 1;
    logic [31:0] slave_rdata = 32'h0;
    bit          rand_ready  = 1'b0;

    int          bus_cycles = 0;
    int          stb_cnt    = 0;
    int          last_run   = 0;
    logic [31:0] last_adr   = 32'h0;
    logic [31:0] last_dat   = 32'h0;
    logic [3:0]  last_sel   = 4'h0;
    logic        last_we    = 1'b0;
    logic        last_cyc   = 1'b0;

    logic [7:0]  tx_q[$];
    int          hold_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wishbone slave model
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hFFFF0000;
        forever begin
            @(posedge clk); #1;
            if (wb_stb_o) begin
                if (stb_cnt == 0) begin
                    bus_cycles++;
                    last_adr = wb_adr_o;
                    last_dat = wb_dat_o;
                    last_sel = wb_sel_o;
                    last_we  = wb_we_o;
                    last_cyc = wb_cyc_o;
                end
                stb_cnt++;
                if (slave_mode != 2 && stb_cnt == slave_delay) begin
                    wb_ack_i = (slave_mode == 0) || (slave_mode == 3);
                    wb_err_i = (slave_mode == 1) || (slave_mode == 3);
                    wb_dat_i = slave_rdata;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                    wb_dat_i = 32'hFFFF0000;
                end
            end else begin
                if (stb_cnt != 0) last_run = stb_cnt;
                stb_cnt  = 0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = 32'hFFFF0000;
            end
        end
    end

    // Transmitter ready driver
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Transmit monitor: logs accepted bytes and checks hold stability
    initial begin
        logic       ph;
        logic [7:0] pd;
        ph = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (ph && (!tx_valid || tx_data !== pd)) hold_viol++;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            ph = tx_valid && !tx_ready;
            pd = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || tx_valid) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " done within budget"}, 32'(busy || tx_valid), 32'h0);
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        int   c0;
        v = vecs[i];
        slave_mode  = v.mode;
        slave_delay = v.delay;
        slave_rdata = v.rdata;
        rand_ready  = v.rr;
        tx_q.delete();
        c0 = bus_cycles;
        for (int k = 0; k < v.ncmd; k++) send_byte(v.cmd[71-8*k -: 8]);
        wait_idle($sformatf("v%0d", i));
        check($sformatf("v%0d tx count", i), tx_q.size(), v.ntx);
        for (int k = 0; k < v.ntx; k++)
            check($sformatf("v%0d tx byte %0d", i, k),
                  (k < tx_q.size()) ? 32'(tx_q[k]) : 32'h100, 32'(v.exp_tx[39-8*k -: 8]));
        check($sformatf("v%0d bus cycles", i), bus_cycles - c0, v.exp_cycles);
        if (v.exp_cycles > 0) begin
            check($sformatf("v%0d adr", i), last_adr, v.exp_adr);
            check($sformatf("v%0d we", i), 32'(last_we), 32'(v.exp_we));
            check($sformatf("v%0d sel", i), 32'(last_sel), 32'hF);
            check($sformatf("v%0d cyc with stb", i), 32'(last_cyc), 32'h1);
            check($sformatf("v%0d stb cycles", i), last_run, v.exp_run);
            if (v.exp_we) check($sformatf("v%0d dat", i), last_dat, v.exp_dat);
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset cyc",      32'(wb_cyc_o), 32'h0);
        check("reset stb",      32'(wb_stb_o), 32'h0);
        check("reset we",       32'(wb_we_o),  32'h0);
        check("reset sel",      32'(wb_sel_o), 32'h0);
        check("reset adr",      wb_adr_o,      32'h0);
        check("reset dat",      wb_dat_o,      32'h0);
        check("reset tx_valid", 32'(tx_valid), 32'h0);
        check("reset tx_data",  32'(tx_data),  32'h0);
        check("reset busy",     32'(busy),     32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        //           cmd                         n  md dl rdata          rr  cy adr           dat           we  run tx               ntx
        vecs[0] = '{72'h02_40000004_00000000, 5, 0, 1, 32'h12345678, 1'b1, 1, 32'h40000004, 32'h0,        1'b0, 1,  40'h06_12345678, 5};
        vecs[1] = '{72'h01_00001000_DEADBEEF, 9, 0, 2, 32'h0,        1'b0, 1, 32'h00001000, 32'hDEADBEEF, 1'b1, 2,  40'h15_00000000 ^ 40'h13_00000000, 1};
        vecs[2] = '{72'h02_00000008_00000000, 5, 2, 1, 32'h0,        1'b0, 1, 32'h00000008, 32'h0,        1'b0, BT, 40'h15_00000000, 1};
        vecs[3] = '{72'h01_00002000_CAFEF00D, 9, 1, 3, 32'h0,        1'b0, 1, 32'h00002000, 32'hCAFEF00D, 1'b1, 3,  40'h15_00000000, 1};
        vecs[4] = '{72'h02_0000000C_00000000, 5, 0, 1, 32'hA5A50F0F, 1'b1, 1, 32'h0000000C, 32'h0,        1'b0, 1,  40'h06_A5A50F0F, 5};
        vecs[5] = '{72'h7F_00000000_00000000, 1, 0, 1, 32'h0,        1'b0, 0, 32'h0,        32'h0,        1'b0, 0,  40'h15_00000000, 1};
        vecs[6] = '{72'h01_00003000_11223344, 9, 3, 1, 32'h0,        1'b0, 1, 32'h00003000, 32'h11223344, 1'b1, 1,  40'h15_00000000, 1};
        vecs[7] = '{72'h02_80000000_00000000, 5, 0, BT, 32'h89ABCDEF, 1'b1, 1, 32'h80000000, 32'h0,       1'b0, BT, 40'h06_89ABCDEF, 5};
        vecs[8] = '{72'h02_00000010_00000000, 5, 1, 1, 32'h55555555, 1'b0, 1, 32'h00000010, 32'h0,        1'b0, 1,  40'h15_00000000, 1};

        // Partial command abandoned: back to idle after exactly RT idle cycles
        tx_q.delete();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (RT - 1) begin @(posedge clk); #1; end
        check("rx timeout busy before limit", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("rx timeout idle at limit", 32'(busy), 32'h0);
        check("rx timeout tx_valid", 32'(tx_valid), 32'h0);
        check("rx timeout no tx", tx_q.size(), 0);

        for (int i = 0; i < NV; i++) apply_vec(i);

        // Reset during an outstanding bus cycle
        slave_mode = 2;
        tx_q.delete();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (3) begin @(posedge clk); #1; end
        check("rst-bus stb before reset", 32'(wb_stb_o), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst-bus cyc", 32'(wb_cyc_o), 32'h0);
        check("rst-bus stb", 32'(wb_stb_o), 32'h0);
        check("rst-bus busy", 32'(busy), 32'h0);
        check("rst-bus tx_valid", 32'(tx_valid), 32'h0);
        rst = 1'b0;
        repeat (BT + 4) begin @(posedge clk); #1; end
        check("rst-bus no tx", tx_q.size(), 0);
        check("rst-bus stays idle", 32'(busy), 32'h0);

        check("tx hold stability", hold_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_host_bridge.md
WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255, the number of clk cycles to wait for wb_ack_i/wb_err_i before aborting a cycle.
REQ-002 SHALL have parameter RX_TIMEOUT, default 65535, the number of idle clk cycles inside a partial command before discarding it.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rx_data  in  8  received byte from the UART receiver.
REQ-006 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-007 tx_data  out  8  byte to the UART transmitter.
REQ-008 tx_valid  out  1  tx_data valid; the byte transfers on a cycle with tx_valid=1 and tx_ready=1.
REQ-009 tx_ready  in  1  transmitter can accept a byte.
REQ-010 wb_adr_o  out  32  Wishbone master address.
REQ-011 wb_dat_o  out  32  Wishbone master write data.
REQ-012 wb_dat_i  in  32  Wishbone read data.
REQ-013 wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o  out  4/1/1/1  Wishbone master controls.
REQ-014 wb_ack_i, wb_err_i  in  1/1  Wishbone slave termination.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 Command framing SHALL be: opcode byte, 4 address bytes MSB first, and for writes 4 data bytes MSB first; opcode 0x01 = write, 0x02 = read.
REQ-017 States SHALL be IDLE, ADDR, WDATA, BUS, RESP, RDATA; a 2-bit byte counter SHALL index bytes within ADDR, WDATA and RDATA.
REQ-018 In IDLE, 0x01/0x02 SHALL latch the opcode and go to ADDR; any other byte SHALL go to RESP with code 0x15 (NAK).
REQ-019 After the 4th address byte, a read SHALL go to BUS and a write SHALL go to WDATA; after the 4th data byte, WDATA SHALL go to BUS.
REQ-020 In BUS, wb_cyc_o and wb_stb_o SHALL be high starting the cycle after entry, with wb_sel_o=4'hF and wb_we_o=1 for writes; adr and dat SHALL stay stable until termination.
REQ-021 Termination SHALL be wb_ack_i or wb_err_i sampled high while wb_stb_o=1; cyc/stb SHALL drop the next cycle (single classic cycle, no bursts).
REQ-022 The response code SHALL be 0x06 (ACK) on wb_ack_i, and 0x15 on wb_err_i or on timeout; wb_ack_i and wb_err_i high together SHALL count as error.
REQ-023 Timeout SHALL occur when BUS_TIMEOUT cycles elapse with stb high and no termination; stb/cyc SHALL drop and the response SHALL be 0x15.
REQ-024 On ack, wb_dat_i SHALL be captured in the same cycle for reads.
REQ-025 RESP SHALL present the code on tx_data with tx_valid=1 until it is accepted.
REQ-026 After RESP, a successful read SHALL go to RDATA and send 4 data bytes MSB first, each held until accepted; all other cases SHALL return to IDLE.
REQ-027 rx_valid in BUS, RESP or RDATA SHALL be ignored (byte dropped).
REQ-028 In ADDR or WDATA, RX_TIMEOUT cycles without rx_valid SHALL return to IDLE silently; the counter SHALL reload on each byte.
REQ-029 tx_valid SHALL never drop before acceptance, and tx_data SHALL not change while tx_valid=1 and tx_ready=0.

Reset
REQ-030 On rst: state=IDLE, counters=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=wb_dat_o=0, tx_valid=0, tx_data=0, busy=0.
REQ-031 rst asserted mid-bus-cycle SHALL drop cyc/stb the next cycle; no response byte SHALL be sent.

Structure
REQ-032 Opcodes (0x01, 0x02), response codes (0x06, 0x15) and the state encoding SHALL live in a shared package, wb_host_pkg.
REQ-033 A single file SHALL hold the design; byte-serial shifting SHALL use one 32-bit shift register per direction, with no sub-module.

Verification
REQ-034 Write: bytes 01 00 00 10 00 DE AD BE EF, slave acks after 2 cycles -> one Wishbone write adr=0x00001000, dat=0xDEADBEEF, sel=F; tx 0x06.
REQ-035 Read: 02 40 00 00 04, slave returns 0x12345678 -> tx 06 12 34 56 78 in order, with tx_ready toggling randomly.
REQ-036 Read, slave never responds (BUS_TIMEOUT=16) -> stb drops after 16 cycles; tx 0x15 only.
REQ-037 Write terminated by wb_err_i -> tx 0x15; a following read still completes correctly.
REQ-038 Bytes 01 00 00 then silence (RX_TIMEOUT=100) -> IDLE after 100 cycles with no tx; a subsequent valid read succeeds. Opcode 0x7F -> tx 0x15.
REQ-039 rst pulsed during BUS -> cyc/stb low within 1 cycle, busy=0, no tx_valid.
